// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register file sizing, control bundle layout
// and the registered response record handed to dispatch.
package rename_pkg;
  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int ARCH_REGS = 32;
  localparam int AREG_W    = 5;
  localparam int FL_DEPTH  = NUM_PREGS - ARCH_REGS;
  localparam int CTRL_W    = 49;

  // Bundle packed MSB-first as {opcode, func3, imm, LoadStore, ALUSrc, ALUControl, BMS}
  localparam int CTRL_BMS_LSB    = 0;
  localparam int CTRL_ALUCTL_LSB = 1;
  localparam int CTRL_ALUSRC_LSB = 5;
  localparam int CTRL_LS_LSB     = 6;
  localparam int CTRL_IMM_LSB    = 7;
  localparam int CTRL_FUNC3_LSB  = 39;
  localparam int CTRL_OPCODE_LSB = 42;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic  reg_write;
    ctrl_t ctrl;
  } rename_rsp_t;
endpackage

// File: rtl/rename_stage_if.sv
// Decode-side request, commit-side free port and dispatch-side response of the
// rename stage. slave = the rename stage, master = its surroundings.
interface rename_stage_if;
  import rename_pkg::*;

  logic  in_valid;
  logic  in_ready;
  areg_t in_rd;
  areg_t in_rs1;
  areg_t in_rs2;
  logic  in_RegWrite;
  ctrl_t in_ctrl;
  logic  free_valid;
  preg_t free_tag;
  logic  out_valid;
  logic  out_ready;
  preg_t out_prs1;
  preg_t out_prs2;
  preg_t out_prd;
  preg_t out_old_prd;
  logic  out_RegWrite;
  ctrl_t out_ctrl;

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_RegWrite, in_ctrl,
    input  free_valid, free_tag, out_ready,
    output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
    output out_RegWrite, out_ctrl
  );

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_RegWrite, in_ctrl,
    output free_valid, free_tag, out_ready,
    input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
    input  out_RegWrite, out_ctrl
  );
endinterface

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags. Resets full, holding FIRST_TAG upward in
// ascending order; pop and push in the same cycle leave count unchanged.
module rename_free_list #(
  parameter  int DEPTH     = 32,
  parameter  int TAG_W     = 6,
  parameter  int FIRST_TAG = 32,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W-1:0] count
);
  logic [DEPTH-1:0][TAG_W-1:0] mem;
  logic [PTR_W-1:0]            head, tail;
  logic                        push_ok, pop_ok;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overflow and p0 returns are dropped; pushes use pre-edge count, so no bypass
  assign push_ok  = push && (push_tag != '0) && (count != TAG_W'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign head_tag = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(FIRST_TAG + i);
      head  <= '0;
      tail  <= '0;
      count <= TAG_W'(DEPTH);
    end else begin
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= wrap_inc(tail);
      end
      if (pop_ok) head <= wrap_inc(head);
      count <= count + TAG_W'(push_ok) - TAG_W'(pop_ok);
    end
  end

  a_push_not_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count != TAG_W'(DEPTH)));
  a_push_not_p0: assert property (@(posedge clk) disable iff (reset)
    push |-> (push_tag != '0));
endmodule

// File: rtl/rename_stage.sv
// Register rename: RAT lookup/update, free-list allocation and a one-entry
// registered output toward dispatch with valid/ready backpressure.
module rename_stage
  import rename_pkg::*;
(
  input logic           clk,
  input logic           reset,
  rename_stage_if.slave bus
);
  logic [ARCH_REGS-1:0][PREG_W-1:0] rat;
  rename_rsp_t out_q;
  logic        out_valid_q;
  preg_t       fl_head, fl_count;
  logic        alloc, in_ready, accept;

  assign alloc    = bus.in_RegWrite && (bus.in_rd != '0);
  assign in_ready = (!out_valid_q || bus.out_ready) && (!alloc || (fl_count != '0));
  assign accept   = bus.in_valid && in_ready;

  rename_free_list #(
    .DEPTH    (FL_DEPTH),
    .TAG_W    (PREG_W),
    .FIRST_TAG(ARCH_REGS)
  ) u_free_list (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.free_valid),
    .push_tag(bus.free_tag),
    .pop     (accept && alloc),
    .head_tag(fl_head),
    .count   (fl_count)
  );

  // Entry 0 is never written (alloc excludes rd == 0), so x0 stays on p0.
  // Reads use pre-edge RAT contents, so rs == rd sees the old mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PREG_W'(i);
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q     <= 1'b1;
      out_q.prs1      <= rat[bus.in_rs1];
      out_q.prs2      <= rat[bus.in_rs2];
      out_q.prd       <= alloc ? fl_head : '0;
      out_q.old_prd   <= alloc ? rat[bus.in_rd] : '0;
      out_q.reg_write <= alloc;
      out_q.ctrl      <= bus.in_ctrl;
      if (alloc) rat[bus.in_rd] <= fl_head;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_prs1     = out_q.prs1;
  assign bus.out_prs2     = out_q.prs2;
  assign bus.out_prd      = out_q.prd;
  assign bus.out_old_prd  = out_q.old_prd;
  assign bus.out_RegWrite = out_q.reg_write;
  assign bus.out_ctrl     = out_q.ctrl;
endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios plus a randomized run against an
// array/queue reference model of the rename rules.
module tb_rename_stage;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rename_stage_if bus();
  rename_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int    rat [ARCH_REGS];
  int    flq [$];
  int    retire_q [$];
  bit    mv;
  preg_t mprs1, mprs2, mprd, mold;
  bit    mrw;
  ctrl_t mctrl;

  function automatic bit m_alloc();
    return bus.in_RegWrite && (bus.in_rd != 0);
  endfunction

  function automatic bit m_ready();
    return (!mv || bus.out_ready) && (!m_alloc() || flq.size() != 0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ARCH_REGS; i++) rat[i] = i;
    flq.delete();
    for (int t = ARCH_REGS; t < NUM_PREGS; t++) flq.push_back(t);
    retire_q.delete();
    mv = 0; mprs1 = '0; mprs2 = '0; mprd = '0; mold = '0; mrw = 0; mctrl = '0;
  endtask

  task automatic m_edge();
    bit acc, al;
    int pre;
    acc = bus.in_valid && m_ready();
    al  = m_alloc();
    pre = flq.size();
    if (acc) begin
      mprs1 = preg_t'(rat[bus.in_rs1]);
      mprs2 = preg_t'(rat[bus.in_rs2]);
      mrw   = al;
      mctrl = bus.in_ctrl;
      mv    = 1;
      if (al) begin
        mprd = preg_t'(flq.pop_front());
        mold = preg_t'(rat[bus.in_rd]);
        rat[bus.in_rd] = int'(mprd);
        retire_q.push_back(int'(mold));
      end else begin
        mprd = '0;
        mold = '0;
      end
    end else if (bus.out_ready) begin
      mv = 0;
    end
    if (bus.free_valid && bus.free_tag != 0 && pre < FL_DEPTH) flq.push_back(int'(bus.free_tag));
  endtask

  task automatic drive(input bit v, input bit rw, input int rd, input int rs1, input int rs2);
    bus.in_valid    = v;
    bus.in_RegWrite = rw;
    bus.in_rd       = areg_t'(rd);
    bus.in_rs1      = areg_t'(rs1);
    bus.in_rs2      = areg_t'(rs2);
    bus.in_ctrl     = CTRL_W'({$urandom(), $urandom()});
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    bus.free_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.free_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    #1;
    n_tests++;
    if ({bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd,
         bus.out_RegWrite, bus.out_ctrl} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b prd=%0d ctrl=%0h, required all zero",
               bus.out_valid, bus.out_prd, bus.out_ctrl);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    ctrl_t c;
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 1, 1, 2, 3);          // add x1,x2,x3
    c = bus.in_ctrl;
    tick();
    n_tests++;
    if ({bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd,
         bus.out_RegWrite, bus.out_ctrl} !== {1'b1, 6'd2, 6'd3, 6'd32, 6'd1, 1'b1, c}) begin
      n_fail++;
      $display("FAIL basic_add1: v=%0b prs1=%0d prs2=%0d prd=%0d old=%0d rw=%0b, required 1/2/3/32/1/1",
               bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd, bus.out_RegWrite);
    end
    drive(1, 1, 4, 1, 1);          // add x4,x1,x1
    tick();
    n_tests++;
    if ({bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd} !== {6'd32, 6'd32, 6'd33, 6'd4}) begin
      n_fail++;
      $display("FAIL basic_dep: prs1=%0d prs2=%0d prd=%0d old=%0d, required 32/32/33/4",
               bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd);
    end
    drive(1, 1, 0, 1, 0);          // addi x0,x1,5
    tick();
    n_tests++;
    if ({bus.out_valid, bus.out_prs1, bus.out_prd, bus.out_old_prd, bus.out_RegWrite} !==
        {1'b1, 6'd32, 6'd0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_x0: v=%0b prs1=%0d prd=%0d old=%0d rw=%0b, required 1/32/0/0/0",
               bus.out_valid, bus.out_prs1, bus.out_prd, bus.out_old_prd, bus.out_RegWrite);
    end
    drive(1, 1, 2, 4, 0);          // next allocation must get 34: x0 write took no tag
    tick();
    n_tests++;
    if ({bus.out_prs1, bus.out_prd, bus.out_old_prd} !== {6'd33, 6'd34, 6'd2}) begin
      n_fail++;
      $display("FAIL basic_after_x0: prs1=%0d prd=%0d old=%0d, required 33/34/2",
               bus.out_prs1, bus.out_prd, bus.out_old_prd);
    end
  endtask

  task automatic test_exhaust();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < FL_DEPTH; i++) begin
      drive(1, 1, 1 + (i % 31), $urandom_range(0, 31), $urandom_range(0, 31));
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_prd !== preg_t'(ARCH_REGS + i)) begin
        n_fail++;
        $display("FAIL exhaust_alloc%0d: v=%0b prd=%0d required 1/%0d", i, bus.out_valid, bus.out_prd, ARCH_REGS + i);
      end
    end
    drive(1, 1, 7, 1, 1);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_stall: in_ready=%0b required 0", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_bubble: out_valid=%0b required 0", bus.out_valid);
    end
    drive(1, 0, 9, 1, 2);          // store: no allocation, still accepted
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL exhaust_store_ready: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_prd !== 6'd0 || bus.out_RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust_store: v=%0b prd=%0d rw=%0b required 1/0/0", bus.out_valid, bus.out_prd, bus.out_RegWrite);
    end
    drive(0, 0, 0, 0, 0);
    bus.free_valid = 1'b1; bus.free_tag = 6'd5;
    tick();
    drive(1, 1, 3, 0, 0);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL free_ready: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_prd !== 6'd5) begin
      n_fail++;
      $display("FAIL free_realloc: prd=%0d required 5", bus.out_prd);
    end
    drive(0, 0, 0, 0, 0);
    bus.free_valid = 1'b1; bus.free_tag = 6'd7;
    tick();
    drive(1, 1, 4, 0, 0);          // pop 7 while pushing 9 at count 1
    bus.free_valid = 1'b1; bus.free_tag = 6'd9;
    tick();
    n_tests++;
    if (bus.out_prd !== 6'd7) begin
      n_fail++;
      $display("FAIL pushpop_pop: prd=%0d required 7", bus.out_prd);
    end
    drive(1, 1, 5, 0, 0);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_count: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_prd !== 6'd9) begin
      n_fail++;
      $display("FAIL pushpop_push: prd=%0d required 9", bus.out_prd);
    end
    drive(1, 1, 6, 0, 0);          // count 0: same-cycle push must not bypass
    bus.free_valid = 1'b1; bus.free_tag = 6'd11;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nobypass: in_ready=%0b required 0", bus.in_ready);
    end
    tick();
    drive(1, 1, 6, 0, 0);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_prd !== 6'd11) begin
      n_fail++;
      $display("FAIL nobypass_next: v=%0b prd=%0d required 1/11", bus.out_valid, bus.out_prd);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 1, 5, 6, 7);
    tick();
    bus.out_ready = 1'b0;
    drive(1, 1, 6, 5, 5);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready%0d: in_ready=%0b required 0", k, bus.in_ready);
      end
      tick();
      n_tests++;
      if ({bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd} !==
          {1'b1, 6'd6, 6'd7, 6'd32, 6'd5}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%0b prs1=%0d prs2=%0d prd=%0d old=%0d required 1/6/7/32/5",
                 k, bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    n_tests++;
    if ({bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd} !== {6'd32, 6'd32, 6'd33, 6'd6}) begin
      n_fail++;
      $display("FAIL bp_after: prs1=%0d prs2=%0d prd=%0d old=%0d required 32/32/33/6",
               bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if (retire_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.free_valid = 1'b1;
        bus.free_tag   = preg_t'(retire_q.pop_front());
      end
      #1;
      n_tests++;
      if (bus.in_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rand_ready@%0d: in_ready=%0b required %0b", cyc, bus.in_ready, m_ready());
      end
      tick();
      n_tests++;
      if (bus.out_valid !== mv ||
          (mv && {bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd, bus.out_RegWrite, bus.out_ctrl}
                 !== {mprs1, mprs2, mprd, mold, mrw, mctrl})) begin
        n_fail++;
        $display("FAIL rand_out@%0d: v=%0b prs=%0d/%0d prd=%0d old=%0d rw=%0b, required v=%0b prs=%0d/%0d prd=%0d old=%0d rw=%0b",
                 cyc, bus.out_valid, bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd, bus.out_RegWrite,
                 mv, mprs1, mprs2, mprd, mold, mrw);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      tick();
    end
    do_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: out_valid=%0b required 0", bus.out_valid);
    end
    for (int i = 0; i < ARCH_REGS / 2; i++) begin
      drive(1, 0, 0, 2 * i, 2 * i + 1);
      tick();
      n_tests++;
      if (bus.out_prs1 !== preg_t'(2 * i) || bus.out_prs2 !== preg_t'(2 * i + 1)) begin
        n_fail++;
        $display("FAIL midreset_rat%0d: prs1=%0d prs2=%0d required %0d/%0d",
                 i, bus.out_prs1, bus.out_prs2, 2 * i, 2 * i + 1);
      end
    end
    drive(1, 1, 3, 3, 1);
    tick();
    n_tests++;
    if ({bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd} !== {6'd3, 6'd1, 6'd32, 6'd3}) begin
      n_fail++;
      $display("FAIL midreset_first: prs1=%0d prs2=%0d prd=%0d old=%0d required 3/1/32/3",
               bus.out_prs1, bus.out_prs2, bus.out_prd, bus.out_old_prd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_RegWrite = 1'b0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_ctrl = '0; bus.free_valid = 1'b0; bus.free_tag = '0;
    bus.out_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_exhaust();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
# rename_stage

Register-rename stage placed directly downstream of the decode stage. Each cycle it accepts at most one decoded instruction and maps its architectural rs1/rs2/rd to physical tags through a register alias table (RAT). It allocates a fresh physical destination from a circular free list and passes the renamed instruction to dispatch through a one-entry registered output with valid/ready backpressure. Commit returns freed physical tags to the free list.

## Interface
- NUM_PREGS, 64, physical register count; must be a power of two and greater than 32
- PREG_W, 6, physical tag width, equal to log2(NUM_PREGS)
- CTRL_W, 49, width of the passthrough control bundle {opcode[6:0], func3[2:0], imm[31:0], LoadStore, ALUSrc, ALUControl[3:0], BMS}
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present; driven by decode is_instruction_valid
- in_ready  out  1  stage accepts the instruction this cycle
- in_rd, in_rs1, in_rs2  in  5 each  architectural register indices
- in_RegWrite  in  1  instruction writes rd
- in_ctrl  in  CTRL_W  control bundle; passed through unmodified
- free_valid  in  1  commit returns a tag this cycle
- free_tag  in  PREG_W  tag being returned
- out_valid  out  1  renamed instruction held in the output register
- out_ready  in  1  dispatch consumes the output this cycle
- out_prs1, out_prs2  out  PREG_W each  physical source tags
- out_prd  out  PREG_W  allocated physical destination; 0 if no allocation
- out_old_prd  out  PREG_W  previous mapping of rd, for release at commit; 0 if no allocation
- out_RegWrite  out  1  registered copy of the allocation decision
- out_ctrl  out  CTRL_W  registered passthrough of in_ctrl

## Operation
- alloc = in_RegWrite && (in_rd != 0). Writes to x0 never allocate; x0 always maps to p0.
- in_ready = (!out_valid || out_ready) && (!alloc || fl_count != 0).
- Accept = in_valid && in_ready. On accept:
  - out_prs1 = RAT[in_rs1] and out_prs2 = RAT[in_rs2]. The RAT is read before the same instruction's update, so add x1,x1,x1 reads the old x1 mapping.
  - If alloc: out_prd = free list head, out_old_prd = RAT[in_rd], RAT[in_rd] <= head tag, head advances, count decrements.
  - Otherwise out_prd = 0 and out_old_prd = 0.
  - out_RegWrite <= alloc, out_ctrl <= in_ctrl, out_valid <= 1.
- If there is no accept and out_ready=1, out_valid <= 0. If out_valid=1 and out_ready=0, all out_* hold their values.
- Free list:
  - Circular FIFO of depth NUM_PREGS-32, with head, tail and count registers (count is PREG_W bits wide so it can reach full).
  - free_valid pushes free_tag at tail, tail advances, count increments.
  - Pointers wrap modulo the depth.
  - A push while count == NUM_PREGS-32 is a protocol violation: it is dropped and flagged by a simulation assertion.
  - free_tag == 0 is also a violation and is dropped.
- Simultaneous pop and push: both happen and count is unchanged. When count == 0 a same-cycle push does not bypass to the pop. in_ready stays low and the tag becomes allocatable next cycle.
- Reset:
  - RAT[i] = i for i = 0..31.
  - Free list holds 32..NUM_PREGS-1 in ascending order from head; head=0, tail=0, count=NUM_PREGS-32.
  - out_valid=0 and all other outputs 0.
  - Reset mid-operation discards the output register and all in-flight mappings unconditionally.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is one instruction per cycle while the free list is non-empty and out_ready=1.
- in_ready is combinational from out_valid, out_ready, in_RegWrite, in_rd and the registered count. There is no path from free_valid to in_ready.
- A tag freed at edge N is allocatable for an instruction accepted at edge N+1 or later.
- A RAT update at edge N is visible to the instruction accepted at edge N+1, so back-to-back dependents need no bypass.

## Structure
- Shared package rename_pkg holds NUM_PREGS, PREG_W, ARCH_REGS=32, CTRL_W, and the ctrl bundle field offsets that decode and dispatch pack and unpack.
- One sub-module, rename_free_list: the parameterised circular FIFO with push/pop/count and reset contents 32..NUM_PREGS-1.
- The RAT (32 x PREG_W flops, p0 hard-wired for x0) and the output register live in rename_stage.

## Test plan
- Reset, then add x1,x2,x3 (RegWrite=1) -> out_prs1=2, out_prs2=3, out_prd=32, out_old_prd=1, out_valid=1 one cycle later.
- Next cycle add x4,x1,x1 -> out_prs1=out_prs2=32, out_prd=33, out_old_prd=4. Then addi x0,x1,5 -> out_prd=0, out_RegWrite=0, free count unchanged.
- 32 consecutive allocating instructions with out_ready=1 -> tags 32..63 in order, then in_ready=0 for a 33rd. A non-writing instruction (store) is still accepted.
- Free list empty, free_valid with free_tag=5 at edge N -> in_ready=1 after edge N, next allocation gets out_prd=5. Push and pop in the same cycle at count=1 -> count stays 1.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0, RAT and count unchanged. Release -> pending instruction accepted next edge.
- reset asserted for one cycle after 10 renames -> RAT identity, count=32, out_valid=0. First rename after reset gets out_prd=32.
